fifo_write_arbiter: RTL and testbench

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

---
 rtl/fifo_arb_pkg.sv | 17 +
 rtl/rr_priority_select.sv | 35 +++
 rtl/fifo_write_arbiter.sv | 165 ++++++++++++++++
 tb/tb_fifo_write_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter.
//   arb_state_e     : arbiter FSM state (IDLE / LOCKED)
//   DEF_NUM_REQ     : default number of requesters
//   DEF_WIDTH       : default data width
//   DEF_TIMEOUT     : default idle cycles before a stalled packet is aborted
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 8;
  localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin priority selector.
// Picks the first asserted request at or after ptr, wrapping modulo N.
//   req     : request vector
//   ptr     : index searched first
//   grant   : one-hot selected request (all-zero when none)
//   any_req : at least one request is asserted
module rr_priority_select #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic             any_req
);

  int   idx;
  logic found;

  always_comb begin
    grant   = '0;
    any_req = |req;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Packet-level arbiter merging NUM_REQ requesters into one FIFO write port.
// A requester is selected round-robin in IDLE, then owns the FIFO until its
// last beat transfers or it stays idle for TIMEOUT cycles.
//
// Handshake: a beat transfers on a rising edge where req_valid_i[k] and
// req_ready_o[k] are both high; valid must not depend on ready. Only the
// owner ever sees ready, and ready follows ~fifo_full_i combinationally, so
// the FIFO is never written while full.
//
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   req_valid_i        : per-requester beat valid
//   req_last_i         : per-requester last beat of packet (with valid)
//   req_data_i         : requester k data in [k*WIDTH +: WIDTH]
//   req_ready_o        : per-requester accept
//   fifo_full_i        : downstream FIFO full
//   fifo_wr_en_o       : FIFO write strobe
//   fifo_write_data_o  : FIFO write data (owner's slice while LOCKED)
//   grant_o            : one-hot owner, zero when unowned
//   busy_o             : high while LOCKED
//   timeout_err_o      : sticky packet-aborted-by-timeout flag
//   state_dbg_o        : current FSM state
//   rr_ptr_dbg_o       : current round-robin pointer
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ-1:0]         req_last_i,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic                       fifo_full_i,
  output logic                       fifo_wr_en_o,
  output logic [WIDTH-1:0]           fifo_write_data_o,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic                       busy_o,
  output logic                       timeout_err_o,
  output arb_state_e                 state_dbg_o,
  output logic [$clog2(NUM_REQ)-1:0] rr_ptr_dbg_o
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_e       state_q, state_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic             timeout_err_q, timeout_err_d;

  logic [NUM_REQ-1:0] sel_grant;
  logic               sel_any;
  logic [PTR_W-1:0]   sel_idx;
  logic [PTR_W-1:0]   owner_next;
  logic               own_valid;
  logic               own_last;
  logic [WIDTH-1:0]   own_data;
  logic               xfer;

  rr_priority_select #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_sel (
    .req     (req_valid_i),
    .ptr     (rr_ptr_q),
    .grant   (sel_grant),
    .any_req (sel_any)
  );

  // One-hot grant from the selector converted to an owner index.
  always_comb begin
    sel_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (sel_grant[k]) sel_idx = PTR_W'(k);
    end
  end

  assign owner_next = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
  assign own_valid  = req_valid_i[owner_q];
  assign own_last   = req_last_i[owner_q];
  assign own_data   = req_data_i[int'(owner_q)*WIDTH +: WIDTH];
  assign xfer       = (state_q == ST_LOCKED) && own_valid && !fifo_full_i;

  // Next-state logic.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    idle_cnt_d    = idle_cnt_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      ST_IDLE: begin
        idle_cnt_d = '0;
        if (sel_any) begin
          owner_d = sel_idx;
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (own_valid) begin
          // Backpressured beats keep the owner alive: valid clears the count.
          idle_cnt_d = '0;
          if (xfer && own_last) begin
            state_d  = ST_IDLE;
            rr_ptr_d = owner_next;
          end
        end else if (idle_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // This cycle is the TIMEOUT-th consecutive idle one: abort.
          state_d       = ST_IDLE;
          rr_ptr_d      = owner_next;
          idle_cnt_d    = '0;
          timeout_err_d = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      owner_q       <= '0;
      rr_ptr_q      <= '0;
      idle_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      idle_cnt_q    <= idle_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Outputs are forced low while rst is high so a reset mid-packet can never
  // produce one more FIFO write in the cycle it is asserted.
  always_comb begin
    req_ready_o       = '0;
    grant_o           = '0;
    fifo_wr_en_o      = 1'b0;
    fifo_write_data_o = '0;
    busy_o            = 1'b0;
    if (!rst && state_q == ST_LOCKED) begin
      grant_o[owner_q]     = 1'b1;
      req_ready_o[owner_q] = !fifo_full_i;
      fifo_wr_en_o         = own_valid && !fifo_full_i;
      fifo_write_data_o    = own_data;
      busy_o               = 1'b1;
    end
  end

  assign timeout_err_o = timeout_err_q && !rst;
  assign state_dbg_o   = state_q;
  assign rr_ptr_dbg_o  = rr_ptr_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter (NUM_REQ=4, WIDTH=8, TIMEOUT=16).
module tb_fifo_write_arbiter;
  import fifo_arb_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  req_valid = '0;
  logic [3:0]  req_last  = '0;
  logic [31:0] req_data  = '0;
  logic [3:0]  req_ready;
  logic        fifo_full = 1'b0;
  logic        fifo_wr_en;
  logic [7:0]  fifo_wdata;
  logic [3:0]  grant;
  logic        busy;
  logic        timeout_err;
  arb_state_e  state_dbg;
  logic [1:0]  rr_ptr_dbg;

  fifo_write_arbiter #(.NUM_REQ(4), .WIDTH(8), .TIMEOUT(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid_i       (req_valid),
    .req_last_i        (req_last),
    .req_data_i        (req_data),
    .req_ready_o       (req_ready),
    .fifo_full_i       (fifo_full),
    .fifo_wr_en_o      (fifo_wr_en),
    .fifo_write_data_o (fifo_wdata),
    .grant_o           (grant),
    .busy_o            (busy),
    .timeout_err_o     (timeout_err),
    .state_dbg_o       (state_dbg),
    .rr_ptr_dbg_o      (rr_ptr_dbg)
  );

  int checks   = 0;
  int failures = 0;

  // scoreboard
  logic [7:0] exp_q[$];
  logic [7:0] wr_q[$];

  always @(negedge clk) begin
    if (fifo_wr_en) wr_q.push_back(fifo_wdata);
  end

  // requester model state
  bit act[4];
  bit hold[4];
  int beat[4];
  int len[4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_drv();
    for (int k = 0; k < 4; k++) begin
      act[k] = 1'b0; hold[k] = 1'b0; beat[k] = 0; len[k] = 1;
    end
    req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
  endtask

  task automatic start_pkt(input int k, input int n);
    act[k] = 1'b1; beat[k] = 0; len[k] = n; hold[k] = 1'b0;
  endtask

  task automatic apply_inputs(input logic full);
    fifo_full = full;
    for (int k = 0; k < 4; k++) begin
      req_valid[k]        = act[k] & ~hold[k];
      req_last[k]         = act[k] && (beat[k] == len[k] - 1);
      req_data[k*8 +: 8]  = 8'(k*16 + beat[k]);
    end
  endtask

  // driver: one clock cycle of all requesters
  task automatic drive_cycle(input logic full);
    apply_inputs(full);
    #1;
    if (full) begin
      chk("stall_ready", 32'(req_ready), 32'h0);
      chk("stall_wr_en", 32'(fifo_wr_en), 32'h0);
    end
    for (int k = 0; k < 4; k++) begin
      if (req_valid[k] && req_ready[k]) begin
        beat[k]++;
        if (beat[k] == len[k]) begin
          act[k] = 1'b0; beat[k] = 0;
        end
      end
    end
    tick();
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int c;
    c = 0;
    while ((act[0] | act[1] | act[2] | act[3]) && c < budget) begin
      drive_cycle(1'b0);
      c++;
    end
    chk(tag, 32'(act[0] | act[1] | act[2] | act[3]), 32'h0);
  endtask

  task automatic compare_writes(input string tag);
    chk({tag, "_count"}, 32'(wr_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && wr_q.size() > 0) begin
      chk({tag, "_data"}, 32'(wr_q.pop_front()), 32'(exp_q.pop_front()));
    end
    exp_q.delete();
    wr_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_drv();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_drv();
    // reset state
    tick();
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_wr_en", 32'(fifo_wr_en), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_terr", 32'(timeout_err), 32'h0);
    tick();
    chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    chk("rst_ptr", 32'(rr_ptr_dbg), 32'h0);
    rst = 1'b0;

    // single-beat packet from requester 0
    req_valid = 4'b0001; req_last = 4'b0001; req_data = 32'h0000_00A5;
    #1;
    chk("a_arb_grant", 32'(grant), 32'h0);
    chk("a_arb_wr_en", 32'(fifo_wr_en), 32'h0);
    tick();
    chk("a_grant", 32'(grant), 32'h1);
    chk("a_ready", 32'(req_ready), 32'h1);
    chk("a_wr_en", 32'(fifo_wr_en), 32'h1);
    chk("a_wdata", 32'(fifo_wdata), 32'hA5);
    chk("a_busy", 32'(busy), 32'h1);
    tick();
    req_valid = '0; req_last = '0; req_data = '0;
    #1;
    chk("a_state", 32'(state_dbg), 32'(ST_IDLE));
    chk("a_ptr", 32'(rr_ptr_dbg), 32'h1);
    chk("a_grant_after", 32'(grant), 32'h0);
    exp_q.push_back(8'hA5);
    compare_writes("a_sb");

    // four requesters, 2-beat packets each, from rr_ptr 0
    do_reset();
    for (int k = 0; k < 4; k++) start_pkt(k, 2);
    run_until_done("b_done", 40);
    foreach (exp_q[i]) exp_q.delete();
    exp_q.push_back(8'h00); exp_q.push_back(8'h01);
    exp_q.push_back(8'h10); exp_q.push_back(8'h11);
    exp_q.push_back(8'h20); exp_q.push_back(8'h21);
    exp_q.push_back(8'h30); exp_q.push_back(8'h31);
    compare_writes("b_sb");
    chk("b_ptr", 32'(rr_ptr_dbg), 32'h0);

    // owner 2 streaming with 3 cycles of backpressure
    start_pkt(2, 4);
    drive_cycle(1'b0);
    chk("c_grant", 32'(grant), 32'h4);
    drive_cycle(1'b0);
    drive_cycle(1'b1);
    drive_cycle(1'b1);
    drive_cycle(1'b1);
    chk("c_busy_stall", 32'(busy), 32'h1);
    run_until_done("c_done", 20);
    exp_q.push_back(8'h20); exp_q.push_back(8'h21);
    exp_q.push_back(8'h22); exp_q.push_back(8'h23);
    compare_writes("c_sb");
    chk("c_terr", 32'(timeout_err), 32'h0);
    chk("c_ptr", 32'(rr_ptr_dbg), 32'h3);

    // requester 3 owns, then only requester 0: pointer wraps
    start_pkt(3, 1);
    drive_cycle(1'b0);
    chk("d_grant3", 32'(grant), 32'h8);
    start_pkt(0, 1);
    drive_cycle(1'b0);
    chk("d_state", 32'(state_dbg), 32'(ST_IDLE));
    chk("d_ptr_wrap", 32'(rr_ptr_dbg), 32'h0);
    drive_cycle(1'b0);
    chk("d_grant0", 32'(grant), 32'h1);
    drive_cycle(1'b0);
    chk("d_ptr", 32'(rr_ptr_dbg), 32'h1);
    exp_q.push_back(8'h30); exp_q.push_back(8'h00);
    compare_writes("d_sb");

    // owner 1 stalls mid-packet for TIMEOUT cycles; requester 2 waits
    start_pkt(1, 4);
    start_pkt(2, 1);
    drive_cycle(1'b0);
    chk("e_grant1", 32'(grant), 32'h2);
    drive_cycle(1'b0);
    hold[1] = 1'b1;
    for (int i = 0; i < 15; i++) drive_cycle(1'b0);
    chk("e_busy_15", 32'(busy), 32'h1);
    chk("e_terr_15", 32'(timeout_err), 32'h0);
    chk("e_grant_15", 32'(grant), 32'h2);
    drive_cycle(1'b0);
    chk("e_state_16", 32'(state_dbg), 32'(ST_IDLE));
    chk("e_terr_16", 32'(timeout_err), 32'h1);
    chk("e_ptr", 32'(rr_ptr_dbg), 32'h2);
    act[1] = 1'b0; hold[1] = 1'b0; beat[1] = 0;
    drive_cycle(1'b0);
    chk("e_grant2", 32'(grant), 32'h4);
    drive_cycle(1'b0);
    chk("e_terr_sticky", 32'(timeout_err), 32'h1);
    exp_q.push_back(8'h10); exp_q.push_back(8'h20);
    compare_writes("e_sb");

    // reset pulsed after beat 2 of a 4-beat packet
    start_pkt(3, 4);
    drive_cycle(1'b0);
    drive_cycle(1'b0);
    drive_cycle(1'b0);
    chk("f_busy_pre", 32'(busy), 32'h1);
    rst = 1'b1;
    apply_inputs(1'b0);
    #1;
    chk("f_rst_wr_en", 32'(fifo_wr_en), 32'h0);
    chk("f_rst_grant", 32'(grant), 32'h0);
    chk("f_rst_ready", 32'(req_ready), 32'h0);
    chk("f_rst_wdata", 32'(fifo_wdata), 32'h0);
    chk("f_rst_busy", 32'(busy), 32'h0);
    chk("f_rst_terr", 32'(timeout_err), 32'h0);
    tick();
    chk("f_rst_state", 32'(state_dbg), 32'(ST_IDLE));
    chk("f_rst_ptr", 32'(rr_ptr_dbg), 32'h0);
    rst = 1'b0;
    clear_drv();
    exp_q.push_back(8'h30); exp_q.push_back(8'h31);
    compare_writes("f_sb_abort");
    start_pkt(1, 1);
    start_pkt(3, 1);
    drive_cycle(1'b0);
    chk("f_grant1", 32'(grant), 32'h2);
    chk("f_terr_after", 32'(timeout_err), 32'h0);
    drive_cycle(1'b0);
    drive_cycle(1'b0);
    chk("f_grant3", 32'(grant), 32'h8);
    drive_cycle(1'b0);
    chk("f_ptr_end", 32'(rr_ptr_dbg), 32'h0);
    exp_q.push_back(8'h10); exp_q.push_back(8'h30);
    compare_writes("f_sb");

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
